// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline register with load alignment, GPR/HI-LO writes and debug trace
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM,
  input  logic        flushW,
  input  logic        MemtoRegW_in,
  input  logic        RegWriteW_in,
  input  logic        HI_LO_write_enableW_in,
  input  logic [63:0] HI_LO_dataW_in,
  input  logic [31:0] ALUoutW_in,
  input  logic [31:0] Memdata_in,
  input  logic [6:0]  WriteRegisterW_in,
  input  logic [2:0]  MemReadTypeW_in,
  input  logic [3:0]  exceptionW_in,
  input  logic [31:0] PCW_in,
  output logic        reg_we,
  output logic [6:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        valid_W,
  output logic [31:0] pc_W,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);
  logic        valid_q;
  logic        mem_to_reg_q;
  logic        reg_write_q;
  logic        hilo_we_q;
  logic [63:0] hilo_data_q;
  logic [31:0] alu_out_q;
  logic [31:0] mem_data_q;
  logic [6:0]  waddr_q;
  logic [2:0]  rtype_q;
  logic [3:0]  exc_q;
  logic [31:0] pc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        commit;
  logic        sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] aligned;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      hilo_we_q    <= 1'b0;
      hilo_data_q  <= '0;
      alu_out_q    <= '0;
      mem_data_q   <= '0;
      waddr_q      <= '0;
      rtype_q      <= '0;
      exc_q        <= '0;
      pc_q         <= RESET_PC;
    end else if (flushW || stallM) begin
      valid_q <= 1'b0;
    end else begin
      valid_q      <= 1'b1;
      mem_to_reg_q <= MemtoRegW_in;
      reg_write_q  <= RegWriteW_in;
      hilo_we_q    <= HI_LO_write_enableW_in;
      hilo_data_q  <= HI_LO_dataW_in;
      alu_out_q    <= ALUoutW_in;
      mem_data_q   <= Memdata_in;
      waddr_q      <= WriteRegisterW_in;
      rtype_q      <= MemReadTypeW_in;
      exc_q        <= exceptionW_in;
      pc_q         <= PCW_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit && hilo_we_q) begin
      hi_q <= hilo_data_q[63:32];
      lo_q <= hilo_data_q[31:0];
    end
  end
  always_comb begin
    commit   = valid_q && (exc_q == 4'h0);
    sext     = !rtype_q[2];
    byte_sel = mem_data_q[{alu_out_q[1:0], 3'b000} +: 8];
    half_sel = alu_out_q[1] ? mem_data_q[31:16] : mem_data_q[15:0];
    aligned  = rtype_q[1:0] == 2'b00 ? {{24{sext & byte_sel[7]}}, byte_sel} :
               rtype_q[1:0] == 2'b01 ? {{16{sext & half_sel[15]}}, half_sel} : mem_data_q;
  end
  assign reg_we            = commit && reg_write_q && (waddr_q != 7'd0);
  assign reg_waddr         = waddr_q;
  assign reg_wdata         = mem_to_reg_q ? aligned : alu_out_q;
  assign hi                = hi_q;
  assign lo                = lo_q;
  assign valid_W           = valid_q;
  assign pc_W              = pc_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{reg_we && (waddr_q[6:5] == 2'b00)}};
  assign debug_wb_rf_wnum  = waddr_q[4:0];
  assign debug_wb_rf_wdata = reg_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed self-checking bench for wb_stage against a behavioural model
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallM = 1'b0;
  logic        flushW = 1'b0;
  logic        MemtoRegW_in = 1'b0;
  logic        RegWriteW_in = 1'b0;
  logic        HI_LO_write_enableW_in = 1'b0;
  logic [63:0] HI_LO_dataW_in = '0;
  logic [31:0] ALUoutW_in = '0;
  logic [31:0] Memdata_in = '0;
  logic [6:0]  WriteRegisterW_in = '0;
  logic [2:0]  MemReadTypeW_in = '0;
  logic [3:0]  exceptionW_in = '0;
  logic [31:0] PCW_in = '0;
  logic        reg_we;
  logic [6:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        valid_W;
  logic [31:0] pc_W;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic        m2r;
    logic        rw;
    logic        hwe;
    logic [63:0] hd;
    logic [31:0] alu;
    logic [31:0] md;
    logic [31:0] pc;
    logic [6:0]  wr;
    logic [2:0]  t;
    logic [3:0]  exc;
  } ins_t;
  ins_t        m;
  logic        m_valid;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  wb_stage dut (
    .clk(clk), .rst(rst), .stallM(stallM), .flushW(flushW),
    .MemtoRegW_in(MemtoRegW_in), .RegWriteW_in(RegWriteW_in),
    .HI_LO_write_enableW_in(HI_LO_write_enableW_in), .HI_LO_dataW_in(HI_LO_dataW_in),
    .ALUoutW_in(ALUoutW_in), .Memdata_in(Memdata_in), .WriteRegisterW_in(WriteRegisterW_in),
    .MemReadTypeW_in(MemReadTypeW_in), .exceptionW_in(exceptionW_in), .PCW_in(PCW_in),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .hi(hi), .lo(lo),
    .valid_W(valid_W), .pc_W(pc_W), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] load_val(input ins_t r);
    int unsigned a = r.alu[1:0];
    logic [31:0] v;
    if (r.t[1:0] == 2'b00) begin
      v = (r.md >> (8 * a)) & 32'hFF;
      if (!r.t[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (r.t[1:0] == 2'b01) begin
      v = (r.md >> (a >= 2 ? 16 : 0)) & 32'hFFFF;
      if (!r.t[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = r.md;
    end
    return v;
  endfunction
  task automatic check_model();
    logic        c;
    logic        we;
    logic [31:0] wd;
    c  = m_valid && m.exc == 4'd0;
    we = c && m.rw && m.wr != 7'd0;
    wd = m.m2r ? load_val(m) : m.alu;
    check("valid_W", valid_W, m_valid);
    check("reg_we", reg_we, we);
    check("reg_waddr", reg_waddr, m.wr);
    check("reg_wdata", reg_wdata, wd);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("pc_W", pc_W, m.pc);
    check("debug_wb_pc", debug_wb_pc, m.pc);
    check("debug_wb_rf_wen", debug_wb_rf_wen, (we && m.wr < 7'd32) ? 4'hF : 4'h0);
    check("debug_wb_rf_wnum", debug_wb_rf_wnum, m.wr % 32);
    check("debug_wb_rf_wdata", debug_wb_rf_wdata, wd);
  endtask
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m       = '{default: '0};
      m.pc    = 32'hBFC0_0000;
      m_valid = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
    end else begin
      if (m_valid && m.exc == 4'd0 && m.hwe) {m_hi, m_lo} = m.hd;
      if (flushW || stallM) m_valid = 1'b0;
      else begin
        m_valid = 1'b1;
        m = '{m2r: MemtoRegW_in, rw: RegWriteW_in, hwe: HI_LO_write_enableW_in,
              hd: HI_LO_dataW_in, alu: ALUoutW_in, md: Memdata_in, pc: PCW_in,
              wr: WriteRegisterW_in, t: MemReadTypeW_in, exc: exceptionW_in};
      end
    end
    #1;
    check_model();
  endtask
  task automatic set_ins(input logic m2r, input logic rw, input logic [31:0] alu,
                         input logic [2:0] t, input logic [6:0] wr, input logic [3:0] exc);
    MemtoRegW_in = m2r;
    RegWriteW_in = rw;
    ALUoutW_in = alu;
    MemReadTypeW_in = t;
    WriteRegisterW_in = wr;
    exceptionW_in = exc;
    PCW_in = PCW_in + 32'd4;
  endtask
  initial begin
    PCW_in = 32'h8000_0000;
    cycle();
    cycle();
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_pc", debug_wb_pc, 32'hBFC0_0000);
    rst = 1'b0;
    Memdata_in = 32'h80FF_7F01;
    set_ins(1'b1, 1'b1, 32'h1000_0002, 3'b000, 7'd5, 4'd0);
    cycle();
    check("sb_we", reg_we, 1'b1);
    check("sb_waddr", reg_waddr, 7'd5);
    check("sb_wdata", reg_wdata, 32'hFFFF_FFFF);
    check("sb_wen", debug_wb_rf_wen, 4'hF);
    set_ins(1'b1, 1'b1, 32'h1000_0002, 3'b101, 7'd5, 4'd0);
    cycle();
    check("lhu_wdata", reg_wdata, 32'h0000_80FF);
    set_ins(1'b1, 1'b1, 32'h1000_0000, 3'b001, 7'd5, 4'd0);
    cycle();
    check("lh_wdata", reg_wdata, 32'h0000_7F01);
    stallM = 1'b1;
    set_ins(1'b0, 1'b1, 32'hCAFE_0001, 3'b010, 7'd9, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_we", reg_we, 1'b0);
    end
    stallM = 1'b0;
    ALUoutW_in = 32'hCAFE_0002;
    cycle();
    check("stall_rel_we", reg_we, 1'b1);
    check("stall_rel_wdata", reg_wdata, 32'hCAFE_0002);
    stallM = 1'b1;
    cycle();
    check("stall_once", reg_we, 1'b0);
    stallM = 1'b0;
    HI_LO_write_enableW_in = 1'b1;
    HI_LO_dataW_in = 64'h1234_5678_9ABC_DEF0;
    set_ins(1'b0, 1'b1, 32'h1, 3'b010, 7'd7, 4'h3);
    cycle();
    check("exc_valid", valid_W, 1'b1);
    check("exc_we", reg_we, 1'b0);
    stallM = 1'b1;
    cycle();
    check("exc_hi", hi, 32'h0);
    check("exc_lo", lo, 32'h0);
    stallM = 1'b0;
    exceptionW_in = 4'h0;
    cycle();
    check("hilo_we", reg_we, 1'b1);
    HI_LO_write_enableW_in = 1'b0;
    stallM = 1'b1;
    cycle();
    check("hilo_hi", hi, 32'h1234_5678);
    check("hilo_lo", lo, 32'h9ABC_DEF0);
    stallM = 1'b0;
    flushW = 1'b1;
    cycle();
    check("flush_valid", valid_W, 1'b0);
    flushW = 1'b0;
    set_ins(1'b0, 1'b1, 32'h55, 3'b010, 7'd0, 4'd0);
    cycle();
    check("r0_we", reg_we, 1'b0);
    set_ins(1'b0, 1'b1, 32'h66, 3'b010, 7'd37, 4'd0);
    cycle();
    check("cp0_we", reg_we, 1'b1);
    check("cp0_wen", debug_wb_rf_wen, 4'h0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      stallM = ($urandom_range(0, 4) == 0);
      flushW = ($urandom_range(0, 7) == 0);
      HI_LO_write_enableW_in = $urandom_range(0, 1);
      HI_LO_dataW_in = {$urandom, $urandom};
      Memdata_in = $urandom;
      set_ins($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 3'($urandom),
              ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
